// File: rtl/unifiedmem_pkg.sv
// Shared types and helpers for the unified-memory client arbiter.
//   NBANKS_DEF : default bank count
//   BANK_W     : width of a client's bank index
//   rsp_t      : registered per-client response {valid, err, rdata}
//   is_legal() : request addresses an existing bank and word
package unifiedmem_pkg;

  localparam int unsigned NBANKS_DEF = 7;
  localparam int unsigned BANK_W     = 3;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned ADDR_CMP_W = 64;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [WORD_W-1:0] rdata;
  } rsp_t;

  // Bank must exist and the word address must fall inside the bank.
  function automatic logic is_legal(input logic [BANK_W-1:0]     bank,
                                    input logic [ADDR_CMP_W-1:0] addr,
                                    input int unsigned           nbanks,
                                    input int unsigned           ramsize);
    return (32'(bank) < nbanks) && (addr < ADDR_CMP_W'(ramsize));
  endfunction

endpackage

// File: rtl/unifiedmem_arbiter_rr.sv
// Per-bank arbiter: picks one requester, searching upward from a start index.
// Build option UNIFIEDMEM_ARB_FIXED_PRIO_EN: pointer ignored, lowest index wins.
//   req   : NREQ-wide candidate vector
//   ptr   : round-robin start index
//   gnt_c : one-hot grant (combinational)
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt_c
);

  logic [PTR_W-1:0] base;
  logic [PTR_W-1:0] idx;
  logic             found;

`ifdef UNIFIEDMEM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign base       = '0;
`else
  assign base = ptr;
`endif

  // First candidate at or after base, wrapping modulo NREQ.
  always_comb begin
    gnt_c = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PTR_W'((32'(base) + k) % NREQ);
      if (!found && req[idx]) begin
        gnt_c[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/unifiedmem_arbiter.sv
// Multi-client front end for the banked unified memory: per-bank arbitration,
// packed memory bus drive, and one-cycle registered responses.
// Build option UNIFIEDMEM_ARB_FIXED_PRIO_EN: fixed lowest-index priority.
//   req_*     : per-client request buses (client i at slice i)
//   req_ready : grant this cycle (combinational)
//   rsp_*     : registered response, one cycle after transfer
//   mem_*     : packed per-bank memory buses; mem_rd is combinational read data
module unifiedmem_arbiter
  import unifiedmem_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NBANKS  = NBANKS_DEF,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned RAMSIZE = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [BANK_W*NREQ-1:0]   req_bank,
  input  logic [WIDTH*NREQ-1:0]    req_addr,
  input  logic [WIDTH*NREQ-1:0]    req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [NREQ-1:0]          rsp_err,
  output logic [WIDTH*NREQ-1:0]    rsp_rdata,
  output logic [NBANKS-1:0]        mem_we,
  output logic [WIDTH*NBANKS-1:0]  mem_a,
  output logic [WIDTH*NBANKS-1:0]  mem_wd,
  input  logic [WIDTH*NBANKS-1:0]  mem_rd
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]                  legal;
  logic [NREQ-1:0]                  served;
  logic [NBANKS-1:0][NREQ-1:0]      cand;
  logic [NBANKS-1:0][NREQ-1:0]      gnt;
  logic [NBANKS-1:0][PTR_W-1:0]     rr_ptr;
  rsp_t [NREQ-1:0]                  rsp_d;
  rsp_t [NREQ-1:0]                  rsp_q;

  // Legality check and per-bank candidate vectors; nothing competes in reset.
  always_comb begin
    legal = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      legal[i] = is_legal(req_bank[i*BANK_W +: BANK_W],
                          ADDR_CMP_W'(req_addr[i*WIDTH +: WIDTH]),
                          NBANKS, RAMSIZE);
      for (int unsigned b = 0; b < NBANKS; b++) begin
        cand[b][i] = rst_n && req_valid[i] && legal[i] &&
                     (32'(req_bank[i*BANK_W +: BANK_W]) == b);
      end
    end
  end

  for (genvar gb = 0; gb < NBANKS; gb++) begin : g_bank
    rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
    ) u_arb (
      .req   (cand[gb]),
      .ptr   (rr_ptr[gb]),
      .gnt_c (gnt[gb])
    );
  end

`ifdef UNIFIEDMEM_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [NBANKS-1:0][PTR_W-1:0] rr_next;

  // Pointer moves past the winner; idle banks keep their pointer.
  always_comb begin
    rr_next = rr_ptr;
    for (int unsigned b = 0; b < NBANKS; b++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gnt[b][i]) rr_next[b] = PTR_W'((i + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= '0;
    else        rr_ptr <= rr_next;
  end
`endif

  // Winner of each bank drives that bank's slice; idle banks drive zero.
  always_comb begin
    mem_we = '0;
    mem_a  = '0;
    mem_wd = '0;
    served = '0;
    for (int unsigned b = 0; b < NBANKS; b++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gnt[b][i]) begin
          mem_we[b]                = req_we[i];
          mem_a[b*WIDTH +: WIDTH]  = req_addr[i*WIDTH +: WIDTH];
          mem_wd[b*WIDTH +: WIDTH] = req_wdata[i*WIDTH +: WIDTH];
          served[i]                = 1'b1;
        end
      end
    end
  end

  // Illegal requests are accepted at once so the client sees an error response.
  assign req_ready = served | (req_valid & ~legal & {NREQ{rst_n}});

  // Next response: loads capture their bank's read data at the grant edge.
  always_comb begin
    rsp_d = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rsp_d[i].valid = req_ready[i];
      rsp_d[i].err   = req_ready[i] && !legal[i];
      for (int unsigned b = 0; b < NBANKS; b++) begin
        if (gnt[b][i] && !req_we[i]) begin
          rsp_d[i].rdata = WORD_W'(mem_rd[b*WIDTH +: WIDTH]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_q <= '0;
    else        rsp_q <= rsp_d;
  end

  always_comb begin
    rsp_valid = '0;
    rsp_err   = '0;
    rsp_rdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rsp_valid[i]                = rsp_q[i].valid;
      rsp_err[i]                  = rsp_q[i].err;
      rsp_rdata[i*WIDTH +: WIDTH] = WIDTH'(rsp_q[i].rdata);
    end
  end

endmodule

// File: tb/tb_unifiedmem_arbiter.sv
// Scoreboard bench for unifiedmem_arbiter with a behavioural banked memory
// (synchronous write, combinational read).
module tb_unifiedmem_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned NB = 7;
  localparam int unsigned NR = 4;
  localparam int unsigned RS = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_we, req_ready;
  logic [3*NR-1:0]   req_bank;
  logic [W*NR-1:0]   req_addr, req_wdata;
  logic [NR-1:0]     rsp_valid, rsp_err;
  logic [W*NR-1:0]   rsp_rdata;
  logic [NB-1:0]     mem_we;
  logic [W*NB-1:0]   mem_a, mem_wd, mem_rd;

  logic [W-1:0]      mem [NB][RS];
  logic              pl_en;
  logic [2:0]        pl_b;
  logic [8:0]        pl_a;
  logic [W-1:0]      pl_d;

  typedef struct { logic err; logic [W-1:0] rdata; } exp_t;
  exp_t exp_q [NR][$];

  int n_checks = 0;
  int n_fail   = 0;

  unifiedmem_arbiter #(.WIDTH(W), .NBANKS(NB), .NREQ(NR), .RAMSIZE(RS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_bank  (req_bank),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  initial forever #5 clk = ~clk;

  // Memory model
  always @(posedge clk) begin
    if (pl_en) mem[pl_b][pl_a] <= pl_d;
    for (int b = 0; b < NB; b++)
      if (mem_we[b]) mem[b][mem_a[b*W +: 9]] <= mem_wd[b*W +: W];
  end

  always_comb begin
    for (int b = 0; b < NB; b++) mem_rd[b*W +: W] = mem[b][mem_a[b*W +: 9]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented response must match the oldest expectation.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (rsp_valid[i] === 1'b1) begin
        if (exp_q[i].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp client %0d: got err=%0b rdata=%0h expected no response",
                   i, rsp_err[i], rsp_rdata[i*W +: W]);
        end else begin
          exp_t e;
          e = exp_q[i].pop_front();
          chk($sformatf("rsp_err%0d", i), 64'(rsp_err[i]), 64'(e.err));
          chk($sformatf("rsp_rdata%0d", i), 64'(rsp_rdata[i*W +: W]), 64'(e.rdata));
        end
      end
    end
  end

  task automatic push(input int c, input logic err, input logic [W-1:0] rdata);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    exp_q[c].push_back(e);
  endtask

  task automatic drive(input int c, input logic we, input logic [2:0] bank,
                       input logic [W-1:0] addr, input logic [W-1:0] wd);
    req_valid[c]         = 1'b1;
    req_we[c]            = we;
    req_bank[c*3 +: 3]   = bank;
    req_addr[c*W +: W]   = addr;
    req_wdata[c*W +: W]  = wd;
  endtask

  task automatic preload(input logic [2:0] b, input logic [8:0] a, input logic [W-1:0] d);
    pl_en = 1'b1; pl_b = b; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic advance();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] exp_rdy;
    rst_n = 1'b0; pl_en = 1'b0;
    req_valid = '1; req_we = '1; req_bank = '0; req_addr = '0; req_wdata = '1;
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_mem_we", 64'(mem_we), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_err", 64'(rsp_err), 64'h0);
    chk("rst_rsp_rdata_nonzero", 64'(rsp_rdata != '0), 64'h0);

    preload(3'd3, 9'd7, 32'h3333_0007);
    preload(3'd2, 9'd5, 32'hA5A5_A5A5);
    for (int i = 0; i < 4; i++) preload(3'(i), 9'(10 + i), 32'hC0DE_0000 + 32'(i));
    req_valid = '0; req_we = '0;
    advance();
    rst_n = 1'b1;

    // Sustained contention on bank 3 straight out of reset
    for (int c = 0; c < NR; c++) drive(c, 1'b0, 3'd3, 32'd7, 32'h0);
    for (int j = 0; j < 4; j++) begin
`ifdef UNIFIEDMEM_ARB_FIXED_PRIO_EN
      exp_rdy = 4'b0001;
`else
      exp_rdy = 4'b0001 << j;
`endif
      settle();
      chk($sformatf("conflict_ready_c%0d", j), 64'(req_ready), 64'(exp_rdy));
      for (int c = 0; c < NR; c++) if (exp_rdy[c]) push(c, 1'b0, 32'h3333_0007);
      advance();
    end
    req_valid = '0;

    // Single load
    drive(0, 1'b0, 3'd2, 32'd5, 32'h0);
    settle();
    chk("load_ready", 64'(req_ready), 64'h1);
    chk("load_mem_a2", 64'(mem_a[2*W +: W]), 64'd5);
    chk("load_mem_we", 64'(mem_we), 64'h0);
    push(0, 1'b0, 32'hA5A5_A5A5);
    advance();
    req_valid = '0;

    // Store then load of the same word
    drive(1, 1'b1, 3'd6, 32'd511, 32'h1234_5678);
    settle();
    chk("store_ready", 64'(req_ready), 64'h2);
    chk("store_mem_we", 64'(mem_we), 64'h40);
    chk("store_mem_wd6", 64'(mem_wd[6*W +: W]), 64'h1234_5678);
    push(1, 1'b0, 32'h0);
    advance();
    drive(1, 1'b0, 3'd6, 32'd511, 32'h0);
    settle();
    chk("reload_ready", 64'(req_ready), 64'h2);
    push(1, 1'b0, 32'h1234_5678);
    advance();
    req_valid = '0;

    // Parallel banks
    for (int c = 0; c < NR; c++) drive(c, 1'b0, 3'(c), 32'(10 + c), 32'h0);
    settle();
    chk("parallel_ready", 64'(req_ready), 64'hF);
    for (int c = 0; c < NR; c++) push(c, 1'b0, 32'hC0DE_0000 + 32'(c));
    advance();
    req_valid = '0;

    // Errors: nonexistent bank, out-of-range store
    drive(2, 1'b0, 3'd7, 32'd0, 32'h0);
    drive(3, 1'b1, 3'd1, 32'd512, 32'hFFFF_FFFF);
    settle();
    chk("err_ready", 64'(req_ready), 64'hC);
    chk("err_mem_we", 64'(mem_we), 64'h0);
    push(2, 1'b1, 32'h0);
    push(3, 1'b1, 32'h0);
    advance();
    req_valid = '0;

    // Reset during a contended burst
    for (int c = 0; c < NR; c++) drive(c, 1'b0, 3'd3, 32'd7, 32'h0);
    settle();
    chk("burst_ready0", 64'(req_ready), 64'h1);
    push(0, 1'b0, 32'h3333_0007);
    advance();
    settle();
`ifdef UNIFIEDMEM_ARB_FIXED_PRIO_EN
    chk("burst_ready1", 64'(req_ready), 64'h1);
`else
    chk("burst_ready1", 64'(req_ready), 64'h2);
`endif
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("midrst_ready", 64'(req_ready), 64'h0);
    chk("midrst_mem_we", 64'(mem_we), 64'h0);
    advance();
    rst_n = 1'b1;
    settle();
    chk("postrst_ready", 64'(req_ready), 64'h1);
    push(0, 1'b0, 32'h3333_0007);
    advance();
    req_valid = '0;
    advance();
    advance();

    for (int c = 0; c < NR; c++)
      chk($sformatf("drained_q%0d", c), 64'(exp_q[c].size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
